// File: rtl/semaforo_rr.sv
// semaforo_rr: N-approach round-robin traffic-light controller with tick prescaler.
// Optional build macro SEMAFORO_FLASH_EN adds a flashing-yellow override input.
module semaforo_rr #(
  parameter int NUM_DIR      = 2,
  parameter int TICK_DIV     = 16000000,
  parameter int MIN_GREEN    = 5,
  parameter int MAX_GREEN    = 20,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 1,
  localparam int CW = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_DIR-1:0]   T,
`ifdef SEMAFORO_FLASH_EN
  input  logic                 flash,
`endif
  output logic [3*NUM_DIR-1:0] L,
  output logic [CW-1:0]        cur,
  output logic                 tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int TW = $clog2(MAX_GREEN + 1);

  localparam logic [1:0] ST_ALLRED = 2'd0;
  localparam logic [1:0] ST_GREEN  = 2'd1;
  localparam logic [1:0] ST_YELLOW = 2'd2;
  localparam logic [1:0] ST_FLASH  = 2'd3;

  localparam logic [3*NUM_DIR-1:0] ALL_RED = {NUM_DIR{3'b100}};

  logic [PW-1:0]        pre;
  logic [NUM_DIR-1:0]   ts1;
  logic [NUM_DIR-1:0]   ts2;
  logic [NUM_DIR-1:0]   other;
  logic [1:0]           state;
  logic [1:0]           state_n;
  logic [TW-1:0]        timer;
  logic [TW-1:0]        timer_n;
  logic [CW-1:0]        nxt;
  logic [CW-1:0]        nxt_n;
  logic [CW-1:0]        cur_n;
  logic [CW-1:0]        pick;
  logic [3*NUM_DIR-1:0] lamp_n;
  logic                 go_y;
  int                   e;

`ifdef SEMAFORO_FLASH_EN
  logic fs1;
  logic fs2;
  logic blink;
  logic blink_n;
`endif

  assign tick  = (pre == PW'(TICK_DIV - 1));
  assign other = ts2 & ~(NUM_DIR'(1) << cur);
  assign e     = int'(timer) + 1;

  // e counts completed green ticks, including the one ending now
  assign go_y = tick && (state == ST_GREEN) && (|other) &&
                ((e >= MIN_GREEN && !ts2[cur]) || e >= MAX_GREEN);

  always_comb begin
    bit found;
    int j;
    pick  = nxt;
    found = 1'b0;
    j     = 0;
    for (int i = 1; i < NUM_DIR; i++) begin
      j = (int'(cur) + i) % NUM_DIR;
      if (!found && other[j]) begin
        found = 1'b1;
        pick  = CW'(j);
      end
    end
  end

  always_comb begin
    state_n = state;
    cur_n   = cur;
    nxt_n   = nxt;
    unique case (1'b1)
      (state == ST_ALLRED): begin
        if (tick && int'(timer) == ALLRED_TICKS - 1) begin
          state_n = ST_GREEN;
          cur_n   = nxt;
        end
      end
      (state == ST_GREEN): begin
        if (go_y) begin
          state_n = ST_YELLOW;
          nxt_n   = pick;
        end
      end
      (state == ST_YELLOW): begin
        if (tick && int'(timer) == YELLOW_TICKS - 1) begin
          state_n = ST_ALLRED;
        end
      end
      default: state_n = ST_ALLRED;
    endcase
`ifdef SEMAFORO_FLASH_EN
    // flash overrides the tick-paced sequence on any edge
    if (fs2) begin
      state_n = ST_FLASH;
      cur_n   = cur;
      nxt_n   = nxt;
    end else if (state == ST_FLASH) begin
      state_n = ST_ALLRED;
      cur_n   = cur;
      nxt_n   = '0;
    end
`endif
  end

  always_comb begin
    timer_n = timer;
    if (state_n != state) begin
      timer_n = '0;
    end else if (tick && int'(timer) < MAX_GREEN) begin
      timer_n = timer + TW'(1);
    end
  end

`ifdef SEMAFORO_FLASH_EN
  always_comb begin
    blink_n = blink;
    if (state_n == ST_FLASH && state != ST_FLASH) begin
      blink_n = 1'b0;
    end else if (state == ST_FLASH && tick) begin
      blink_n = ~blink;
    end
  end
`endif

  always_comb begin
    lamp_n = ALL_RED;
    for (int k = 0; k < NUM_DIR; k++) begin
      if (state_n == ST_GREEN && int'(cur_n) == k) begin
        lamp_n[3*k +: 3] = 3'b001;
      end else if (state_n == ST_YELLOW && int'(cur_n) == k) begin
        lamp_n[3*k +: 3] = 3'b010;
      end
`ifdef SEMAFORO_FLASH_EN
      if (state_n == ST_FLASH) begin
        lamp_n[3*k +: 3] = {1'b0, blink_n, 1'b0};
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre   <= '0;
      ts1   <= '0;
      ts2   <= '0;
      state <= ST_ALLRED;
      timer <= '0;
      cur   <= CW'(NUM_DIR - 1);
      nxt   <= '0;
      L     <= ALL_RED;
`ifdef SEMAFORO_FLASH_EN
      fs1   <= 1'b0;
      fs2   <= 1'b0;
      blink <= 1'b0;
`endif
    end else begin
      pre   <= tick ? '0 : pre + PW'(1);
      ts1   <= T;
      ts2   <= ts1;
      state <= state_n;
      timer <= timer_n;
      cur   <= cur_n;
      nxt   <= nxt_n;
      L     <= lamp_n;
`ifdef SEMAFORO_FLASH_EN
      fs1   <= flash;
      fs2   <= fs1;
      blink <= blink_n;
`endif
    end
  end

endmodule

// File: tb/tb_semaforo_rr.sv
// tb_semaforo_rr: vector table, hand sequences and random run for semaforo_rr.
// Two instances (2 and 4 approaches) are tracked by a tick-level phase model.
module tb_semaforo_rr;

  localparam int TDIV = 4;
  localparam int MING = 3;
  localparam int MAXG = 6;
  localparam int YEL  = 2;
  localparam int AR   = 1;

  localparam int PH_AR = 0;
  localparam int PH_G  = 1;
  localparam int PH_Y  = 2;
  localparam int PH_F  = 3;

  logic       clk = 1'b0;
  logic       rst2 = 1'b1;
  logic       rst4 = 1'b1;
  logic [1:0] t2 = '0;
  logic [3:0] t4 = '0;
  logic       fl2 = 1'b0;
  logic       fl4 = 1'b0;
  logic [5:0]  l2;
  logic [11:0] l4;
  logic        cur2;
  logic [1:0]  cur4;
  logic        tick2;
  logic        tick4;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  semaforo_rr #(
    .NUM_DIR(2), .TICK_DIV(TDIV), .MIN_GREEN(MING),
    .MAX_GREEN(MAXG), .YELLOW_TICKS(YEL), .ALLRED_TICKS(AR)
  ) dut2 (
    .clk(clk),
    .reset(rst2),
    .T(t2),
`ifdef SEMAFORO_FLASH_EN
    .flash(fl2),
`endif
    .L(l2),
    .cur(cur2),
    .tick(tick2)
  );

  semaforo_rr #(
    .NUM_DIR(4), .TICK_DIV(TDIV), .MIN_GREEN(MING),
    .MAX_GREEN(MAXG), .YELLOW_TICKS(YEL), .ALLRED_TICKS(AR)
  ) dut4 (
    .clk(clk),
    .reset(rst4),
    .T(t4),
`ifdef SEMAFORO_FLASH_EN
    .flash(fl4),
`endif
    .L(l4),
    .cur(cur4),
    .tick(tick4)
  );

  typedef struct packed {
    int         ph;
    int         el;
    int         owner;
    int         queued;
    int         pc;
    int         blink;
    logic [7:0] s1;
    logic [7:0] s2;
    logic       f1;
    logic       f2;
  } mdl_t;

  mdl_t m2;
  mdl_t m4;

  function automatic mdl_t mreset(int nd);
    mdl_t m;
    m = '0;
    m.owner = nd - 1;
    return m;
  endfunction

  function automatic mdl_t mstep(mdl_t m, logic [7:0] t, logic fl, int nd);
    mdl_t n;
    bit tk;
    bit oth;
    bit found;
    int j;
    n = m;
    tk = (m.pc == TDIV - 1);
    oth = 1'b0;
    found = 1'b0;
    n.pc = (m.pc + 1) % TDIV;
    n.s2 = m.s1;
    n.s1 = t;
    n.f2 = m.f1;
    n.f1 = fl;
    if (m.f2) begin
      if (m.ph != PH_F) begin
        n.ph = PH_F;
        n.el = 0;
        n.blink = 0;
      end else if (tk) begin
        n.blink = 1 - m.blink;
      end
    end else if (m.ph == PH_F) begin
      n.ph = PH_AR;
      n.el = 0;
      n.queued = 0;
    end else if (tk) begin
      case (m.ph)
        PH_AR: begin
          if (m.el + 1 >= AR) begin
            n.ph = PH_G;
            n.el = 0;
            n.owner = m.queued;
          end else n.el = m.el + 1;
        end
        PH_G: begin
          for (int k = 0; k < nd; k++)
            if (k != m.owner && m.s2[k]) oth = 1'b1;
          if (oth && ((m.el + 1 >= MING && !m.s2[m.owner]) ||
                      m.el + 1 >= MAXG)) begin
            n.ph = PH_Y;
            n.el = 0;
            for (int i = 1; i < nd; i++) begin
              j = (m.owner + i) % nd;
              if (!found && m.s2[j]) begin
                found = 1'b1;
                n.queued = j;
              end
            end
          end else n.el = m.el + 1;
        end
        PH_Y: begin
          if (m.el + 1 >= YEL) begin
            n.ph = PH_AR;
            n.el = 0;
          end else n.el = m.el + 1;
        end
        default: n.ph = PH_AR;
      endcase
    end
    return n;
  endfunction

  function automatic logic [23:0] mlamps(mdl_t m, int nd);
    logic [23:0] r;
    r = '0;
    for (int k = 0; k < nd; k++) begin
      if (m.ph == PH_F) r[3*k+1] = (m.blink != 0);
      else if (m.ph == PH_G && k == m.owner) r[3*k] = 1'b1;
      else if (m.ph == PH_Y && k == m.owner) r[3*k+1] = 1'b1;
      else r[3*k+2] = 1'b1;
    end
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] a, logic [31:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, a, x, $time);
    end
  endtask

  always @(posedge clk or posedge rst2)
    if (rst2) m2 = mreset(2);
    else m2 = mstep(m2, {6'b0, t2}, fl2, 2);

  always @(posedge clk or posedge rst4)
    if (rst4) m4 = mreset(4);
    else m4 = mstep(m4, {4'b0, t4}, fl4, 4);

  always @(negedge clk) begin
    logic [23:0] x;
    if (chk_en) begin
      x = mlamps(m2, 2);
      chk("L2_model", 32'(l2), 32'(x[5:0]));
      chk("cur2_model", 32'(cur2), 32'(m2.owner));
      chk("tick2_model", 32'(tick2), 32'(m2.pc == TDIV - 1));
      x = mlamps(m4, 4);
      chk("L4_model", 32'(l4), 32'(x[11:0]));
      chk("cur4_model", 32'(cur4), 32'(m4.owner));
      chk("tick4_model", 32'(tick4), 32'(m4.pc == TDIV - 1));
    end
  end

  typedef struct {
    bit         rst;
    logic [1:0] t;
    int         cyc;
    logic [5:0] l;
    logic       c;
  } vec_t;

  vec_t tbl [18];

  initial begin
    tbl[0]  = '{1'b1, 2'b00, 3,  6'b100100, 1'b1};
    tbl[1]  = '{1'b0, 2'b00, 1,  6'b100001, 1'b0};
    tbl[2]  = '{1'b0, 2'b00, 40, 6'b100001, 1'b0};
    tbl[3]  = '{1'b1, 2'b00, 4,  6'b100001, 1'b0};
    tbl[4]  = '{1'b0, 2'b10, 11, 6'b100001, 1'b0};
    tbl[5]  = '{1'b0, 2'b10, 1,  6'b100010, 1'b0};
    tbl[6]  = '{1'b0, 2'b10, 7,  6'b100010, 1'b0};
    tbl[7]  = '{1'b0, 2'b10, 1,  6'b100100, 1'b0};
    tbl[8]  = '{1'b0, 2'b10, 3,  6'b100100, 1'b0};
    tbl[9]  = '{1'b0, 2'b10, 1,  6'b001100, 1'b1};
    tbl[10] = '{1'b0, 2'b10, 20, 6'b001100, 1'b1};
    tbl[11] = '{1'b1, 2'b11, 4,  6'b100001, 1'b0};
    tbl[12] = '{1'b0, 2'b11, 23, 6'b100001, 1'b0};
    tbl[13] = '{1'b0, 2'b11, 1,  6'b100010, 1'b0};
    tbl[14] = '{1'b0, 2'b11, 8,  6'b100100, 1'b0};
    tbl[15] = '{1'b0, 2'b11, 4,  6'b001100, 1'b1};
    tbl[16] = '{1'b0, 2'b11, 23, 6'b001100, 1'b1};
    tbl[17] = '{1'b0, 2'b11, 1,  6'b010100, 1'b1};

    repeat (2) @(negedge clk);
    chk_en = 1'b1;

    foreach (tbl[i]) begin
      #1;
      t2 = tbl[i].t;
      if (tbl[i].rst) begin
        rst2 = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_L", 32'(l2), 32'h24);
        chk("rst_cur", 32'(cur2), 32'd1);
        chk("rst_tick", 32'(tick2), 32'd0);
        #1 rst2 = 1'b0;
      end
      repeat (tbl[i].cyc) @(negedge clk);
      chk($sformatf("vec%0d_L", i), 32'(l2), 32'(tbl[i].l));
      chk($sformatf("vec%0d_cur", i), 32'(cur2), 32'(tbl[i].c));
    end

    // one-clock async reset during yellow1
    #1 rst2 = 1'b1;
    #1;
    chk("async_rst_L", 32'(l2), 32'h24);
    chk("async_rst_cur", 32'(cur2), 32'd1);
    @(negedge clk);
    #1 rst2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_allred", 32'(l2), 32'h24);
    chk("post_rst_tick", 32'(tick2), 32'd1);
    @(negedge clk);
    chk("post_rst_green0", 32'(l2), 32'h21);
    chk("post_rst_cur0", 32'(cur2), 32'd0);

    // four approaches: round-robin skips the idle approach 2
    #1 rst4 = 1'b1;
    t4 = 4'b0010;
    repeat (2) @(negedge clk);
    #1 rst4 = 1'b0;
    repeat (28) @(negedge clk);
    chk("d4_green1", 32'(l4), 32'h90C);
    chk("d4_cur1", 32'(cur4), 32'd1);
    #1 t4 = 4'b0000;
    repeat (13) @(negedge clk);
    chk("d4_rest1", 32'(l4), 32'h90C);
    #1 t4 = 4'b1001;
    repeat (3) @(negedge clk);
    chk("d4_yellow1", 32'(l4), 32'h914);
    #1 t4 = 4'b0101;
    repeat (12) @(negedge clk);
    chk("d4_green3", 32'(l4), 32'h324);
    chk("d4_cur3", 32'(cur4), 32'd3);

`ifdef SEMAFORO_FLASH_EN
    #1 rst2 = 1'b1;
    t2 = 2'b10;
    fl2 = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst2 = 1'b0;
    repeat (30) @(negedge clk);
    chk("fl_green1", 32'(l2), 32'h0C);
    #1 fl2 = 1'b1;
    repeat (2) @(negedge clk);
    chk("fl_sync_delay", 32'(l2), 32'h0C);
    @(negedge clk);
    chk("fl_enter", 32'(l2), 32'h00);
    repeat (3) @(negedge clk);
    chk("fl_blink_on", 32'(l2), 32'h12);
    repeat (4) @(negedge clk);
    chk("fl_blink_off", 32'(l2), 32'h00);
    #1 fl2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("fl_exit_allred", 32'(l2), 32'h24);
    chk("fl_exit_cur", 32'(cur2), 32'd1);
    @(negedge clk);
    chk("fl_green0", 32'(l2), 32'h21);
    chk("fl_green0_cur", 32'(cur2), 32'd0);
`endif

    for (int s = 0; s < 400; s++) begin
      #1;
      t2 = 2'($urandom_range(0, 3));
      t4 = 4'($urandom_range(0, 15));
`ifdef SEMAFORO_FLASH_EN
      if ($urandom_range(0, 24) == 0) fl2 = ~fl2;
`endif
      repeat ($urandom_range(1, 12)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
